// File: rtl/udma_cfg_apb_bridge.sv
// APB slave that forwards each transfer as one cfg-bus handshake to one of
// N_PERIPHS uDMA peripheral register files and returns data/ready/error.
module udma_cfg_apb_bridge #(
  parameter int N_PERIPHS = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic [31:0]             paddr_i,
  input  logic [31:0]             pwdata_i,
  input  logic                    pwrite_i,
  input  logic                    psel_i,
  input  logic                    penable_i,
  output logic [31:0]             prdata_o,
  output logic                    pready_o,
  output logic                    pslverr_o,
  output logic [N_PERIPHS-1:0]    cfg_valid_o,
  output logic                    cfg_rwn_o,
  output logic [4:0]              cfg_addr_o,
  output logic [31:0]             cfg_data_o,
  input  logic [32*N_PERIPHS-1:0] cfg_data_i,
  input  logic [N_PERIPHS-1:0]    cfg_ready_i
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  logic [4:0]             addr_q, addr_d;
  logic [3:0]             idx_q, idx_d;
  logic [31:0]            data_q, data_d;
  logic                   rwn_q, rwn_d;
  logic [7:0]             cnt_q, cnt_d;
  logic [N_PERIPHS-1:0]   valid_q, valid_d;
  logic [31:0]            prdata_q, prdata_d;
  logic                   pready_q, pready_d;
  logic                   pslverr_q, pslverr_d;

  logic                   setup;
  logic                   idx_ok;
  logic [N_PERIPHS-1:0]   setup_onehot;
  logic [N_PERIPHS-1:0]   idx_onehot;
  logic                   ready_hit;
  logic [31:0]            rdata_sel;
  logic                   unused_paddr;

  assign setup        = psel_i & ~penable_i;
  assign idx_ok       = int'(paddr_i[10:7]) < N_PERIPHS;
  assign unused_paddr = ^{paddr_i[31:11], paddr_i[1:0]};

  // Decode the incoming index and the latched index; only the latched one
  // may qualify ready and read data, so other peripherals are ignored.
  always_comb begin
    setup_onehot = '0;
    idx_onehot   = '0;
    rdata_sel    = '0;
    for (int k = 0; k < N_PERIPHS; k++) begin
      setup_onehot[k] = (int'(paddr_i[10:7]) == k);
      idx_onehot[k]   = (int'(idx_q) == k);
      if (idx_onehot[k]) rdata_sel = cfg_data_i[32*k +: 32];
    end
  end

  assign ready_hit = |(cfg_ready_i & idx_onehot);

  always_comb begin
    // NOTE: every signal gets its default before the case so no branch can infer a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    idx_d     = idx_q;
    data_d    = data_q;
    rwn_d     = rwn_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (setup) begin
          addr_d = paddr_i[6:2];
          idx_d  = paddr_i[10:7];
          data_d = pwdata_i;
          rwn_d  = ~pwrite_i;
          if (idx_ok) begin
            valid_d = setup_onehot;
            cnt_d   = '0;
            state_d = REQ;
          end else begin
            prdata_d  = '0;
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            state_d   = DONE;
          end
        end
      end
      REQ: begin
        // Drop valid on the ready cycle so a read side effect fires exactly once.
        if (ready_hit) begin
          prdata_d = rwn_q ? rdata_sel : '0;
          valid_d  = '0;
          pready_d = 1'b1;
          state_d  = DONE;
        end else if (cnt_q == CNT_LAST) begin
          valid_d   = '0;
          prdata_d  = '0;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          state_d   = DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      data_q    <= '0;
      rwn_q     <= 1'b1;  // idle bus reads as a read, never a stray write
      cnt_q     <= '0;
      valid_q   <= '0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      rwn_q     <= rwn_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  assign prdata_o    = prdata_q;
  assign pready_o    = pready_q;
  assign pslverr_o   = pslverr_q;
  assign cfg_valid_o = valid_q;
  assign cfg_rwn_o   = rwn_q;
  assign cfg_addr_o  = addr_q;
  assign cfg_data_o  = data_q;

endmodule

// File: tb/tb_udma_cfg_apb_bridge.sv
// Self-checking bench: directed vector table, reset corner, then random APB
// traffic against a register-file model with timing derived from the latency rules.
module tb_udma_cfg_apb_bridge;

  localparam int N    = 8;
  localparam int TO_B = 4;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          wr;
    int          dly;     // cycles of ready low after T1; -1 = never ready
    bit          use_b;   // 1 = instance with TIMEOUT=4
    logic [31:0] exp_rd;
    bit          exp_err;
    int          exp_lat; // cycle index of pready, setup phase = 0
  } vec_t;

  logic clk = 1'b0;
  logic rstn;
  logic [31:0] paddr, pwdata;
  logic pwrite, psel, penable, use_b;
  logic psel_a, psel_b;
  logic [32*N-1:0] cfg_data;
  logic [N-1:0] cfg_ready;

  logic [31:0] prdata_a, prdata_b, cfg_data_a, cfg_data_b;
  logic pready_a, pready_b, pslverr_a, pslverr_b, rwn_a, rwn_b;
  logic [N-1:0] valid_a, valid_b;
  logic [4:0] addr_a, addr_b;

  logic [31:0] prdata_m, cfg_data_m;
  logic pready_m, pslverr_m, cfg_rwn_m;
  logic [N-1:0] valid_m;
  logic [4:0] cfg_addr_m;

  logic [31:0] periph_mem [N][32];
  logic [31:0] model      [N][32];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign psel_a     = psel & ~use_b;
  assign psel_b     = psel & use_b;
  assign prdata_m   = use_b ? prdata_b   : prdata_a;
  assign pready_m   = use_b ? pready_b   : pready_a;
  assign pslverr_m  = use_b ? pslverr_b  : pslverr_a;
  assign valid_m    = use_b ? valid_b    : valid_a;
  assign cfg_rwn_m  = use_b ? rwn_b      : rwn_a;
  assign cfg_addr_m = use_b ? addr_b     : addr_a;
  assign cfg_data_m = use_b ? cfg_data_b : cfg_data_a;

  udma_cfg_apb_bridge #(.N_PERIPHS(N)) dut_a (
    .clk_i(clk), .rstn_i(rstn),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel_a), .penable_i(penable),
    .prdata_o(prdata_a), .pready_o(pready_a), .pslverr_o(pslverr_a),
    .cfg_valid_o(valid_a), .cfg_rwn_o(rwn_a), .cfg_addr_o(addr_a),
    .cfg_data_o(cfg_data_a), .cfg_data_i(cfg_data), .cfg_ready_i(cfg_ready)
  );

  udma_cfg_apb_bridge #(.N_PERIPHS(N), .TIMEOUT(TO_B)) dut_b (
    .clk_i(clk), .rstn_i(rstn),
    .paddr_i(paddr), .pwdata_i(pwdata), .pwrite_i(pwrite),
    .psel_i(psel_b), .penable_i(penable),
    .prdata_o(prdata_b), .pready_o(pready_b), .pslverr_o(pslverr_b),
    .cfg_valid_o(valid_b), .cfg_rwn_o(rwn_b), .cfg_addr_o(addr_b),
    .cfg_data_o(cfg_data_b), .cfg_data_i(cfg_data), .cfg_ready_i(cfg_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // One APB transfer; the peripheral answers after v.dly wait cycles with
  // garbage on every data lane except the addressed one in its ready cycle.
  task automatic xfer(input vec_t v, output logic [31:0] rd, output bit err,
                      output int lat, output int vcnt);
    int idx;
    int cyc;
    bit done;
    logic [N-1:0] mask;
    idx  = int'(v.addr[10:7]);
    mask = '0;
    if (idx < N) mask[idx] = 1'b1;
    rd = '0; err = 1'b0; lat = -1; vcnt = 0; done = 1'b0; cyc = 0;

    @(posedge clk); #1;
    use_b = v.use_b; psel = 1'b1; penable = 1'b0;
    paddr = v.addr; pwdata = v.wdata; pwrite = v.wr; cfg_ready = '0;
    while (!done && cyc < 300) begin
      @(posedge clk); #1;
      cyc++;
      penable = 1'b1;
      for (int k = 0; k < N; k++) cfg_data[32*k +: 32] = $urandom;
      cfg_ready = N'($urandom) & ~mask;
      if (idx < N && v.dly >= 0 && cyc - 1 == v.dly) begin
        cfg_ready[idx] = 1'b1;
        cfg_data[32*idx +: 32] = periph_mem[idx][cfg_addr_m];
      end
      @(negedge clk);
      if (|valid_m) begin
        vcnt++;
        check("valid_onehot", 32'(valid_m), 32'(mask));
        check("cfg_addr", 32'(cfg_addr_m), 32'(v.addr[6:2]));
        check("cfg_data", cfg_data_m, v.wdata);
        check("cfg_rwn", 32'(cfg_rwn_m), 32'(!v.wr));
        if (idx < N && cfg_ready[idx] && !cfg_rwn_m) periph_mem[idx][cfg_addr_m] = cfg_data_m;
      end
      if (pready_m) begin
        done = 1'b1; lat = cyc; rd = prdata_m; err = pslverr_m;
      end
    end
    check("pready_seen", 32'(done), 32'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; cfg_ready = '0;
    @(negedge clk);
    check("pready_single", 32'(pready_m), 32'd0);
    check("prdata_hold", prdata_m, rd);
  endtask

  task automatic run(input vec_t v, input string tag);
    logic [31:0] rd;
    bit err;
    int lat, vcnt, idx;
    xfer(v, rd, err, lat, vcnt);
    check({tag, "_prdata"}, rd, v.exp_rd);
    check({tag, "_pslverr"}, 32'(err), 32'(v.exp_err));
    check({tag, "_latency"}, lat, v.exp_lat);
    check({tag, "_valid_cycles"}, vcnt, v.exp_lat - 1);
    idx = int'(v.addr[10:7]);
    if (v.wr && !v.exp_err && idx < N) model[idx][v.addr[6:2]] = v.wdata;
  endtask

  initial begin
    vec_t tbl [12];
    vec_t v;
    int idx;

    psel = 0; penable = 0; paddr = 0; pwdata = 0; pwrite = 0; use_b = 0;
    cfg_ready = '0; cfg_data = '0; rstn = 1'b0;
    for (int k = 0; k < N; k++)
      for (int r = 0; r < 32; r++) begin
        periph_mem[k][r] = $urandom;
        model[k][r]      = periph_mem[k][r];
      end
    periph_mem[0][8] = 32'h3;         model[0][8] = 32'h3;
    periph_mem[3][1] = 32'h0BAD_F00D; model[3][1] = 32'h0BAD_F00D;

    #12;
    check("rst_valid",   32'(valid_a),   32'd0);
    check("rst_rwn",     32'(rwn_a),     32'd1);
    check("rst_addr",    32'(addr_a),    32'd0);
    check("rst_data",    cfg_data_a,     32'd0);
    check("rst_prdata",  prdata_a,       32'd0);
    check("rst_pready",  32'(pready_a),  32'd0);
    check("rst_pslverr", 32'(pslverr_a), 32'd0);
    @(negedge clk);
    rstn = 1'b1;

    //           addr           wdata          wr dly b  exp_rd         err lat
    tbl[0]  = '{32'h0000_0094, 32'h0000_1234, 1,  0, 0, 32'h0,         0,  2};
    tbl[1]  = '{32'h0000_0020, 32'hDEAD_0000, 0,  0, 0, 32'h3,         0,  2};
    tbl[2]  = '{32'h0000_0094, 32'h0,         0,  1, 0, 32'h1234,      0,  3};
    tbl[3]  = '{32'h0000_010C, 32'hCAFE_F00D, 1,  4, 0, 32'h0,         0,  6};
    tbl[4]  = '{32'h0000_010C, 32'h0,         0,  4, 0, 32'hCAFE_F00D, 0,  6};
    tbl[5]  = '{32'h0000_0480, 32'h1111_1111, 0,  0, 0, 32'h0,         1,  1};
    tbl[6]  = '{32'h0000_07FC, 32'h2222_2222, 1,  0, 0, 32'h0,         1,  1};
    tbl[7]  = '{32'h0000_03FC, 32'hA5A5_5A5A, 1,  2, 0, 32'h0,         0,  4};
    tbl[8]  = '{32'hFFFF_FBFC, 32'h0,         0,  0, 0, 32'hA5A5_5A5A, 0,  2};
    tbl[9]  = '{32'h0000_0020, 32'h0,         0,  0, 1, 32'h3,         0,  2};
    tbl[10] = '{32'h0000_0184, 32'h0,         0,  3, 1, 32'h0BAD_F00D, 0,  5};
    tbl[11] = '{32'h0000_0184, 32'h0,         0, -1, 1, 32'h0,         1,  5};
    for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

    // Reset while the request is outstanding, then a clean read.
    @(posedge clk); #1;
    use_b = 0; psel = 1; penable = 0; paddr = 32'h0000_0120; pwdata = 32'h5555_0000;
    pwrite = 0; cfg_ready = '0;
    @(posedge clk); #1;
    penable = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid_valid", 32'(valid_a), 32'h4);
    rstn = 1'b0;
    #1;
    check("mid_rst_valid",   32'(valid_a),   32'd0);
    check("mid_rst_rwn",     32'(rwn_a),     32'd1);
    check("mid_rst_addr",    32'(addr_a),    32'd0);
    check("mid_rst_data",    cfg_data_a,     32'd0);
    check("mid_rst_prdata",  prdata_a,       32'd0);
    check("mid_rst_pready",  32'(pready_a),  32'd0);
    check("mid_rst_pslverr", 32'(pslverr_a), 32'd0);
    @(posedge clk); #1;
    psel = 0; penable = 0;
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_reissue", 32'(valid_a), 32'd0);
    end
    v = '{32'h0000_0020, 32'h0, 0, 0, 0, 32'h3, 0, 2};
    run(v, "post_rst");

    // Random traffic: expectations from the register model and latency rules.
    for (int i = 0; i < 200; i++) begin
      v.addr = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr[10:7] = 4'($urandom_range(0, N - 1));
      v.wdata = $urandom;
      v.wr    = 1'($urandom_range(0, 1));
      v.use_b = 1'($urandom_range(0, 1));
      v.dly   = v.use_b ? int'($urandom_range(0, 4)) - 1 : int'($urandom_range(0, 5));
      idx     = int'(v.addr[10:7]);
      if (idx >= N) begin
        v.exp_err = 1; v.exp_rd = '0; v.exp_lat = 1;
      end else if (v.dly < 0) begin
        v.exp_err = 1; v.exp_rd = '0; v.exp_lat = 1 + TO_B;
      end else begin
        v.exp_err = 0; v.exp_lat = v.dly + 2;
        v.exp_rd  = v.wr ? 32'h0 : model[idx][v.addr[6:2]];
      end
      run(v, "rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udma_cfg_apb_bridge.md
# udma_cfg_apb_bridge

APB-to-uDMA configuration bus bridge: the initiator end of the per-peripheral cfg register interface (cfg_valid/cfg_rwn/cfg_addr/cfg_data/cfg_ready). It decodes an APB access to one of N peripheral register files, such as the I2C register interface. It drives exactly one single-cycle-or-held cfg handshake per APB transfer and returns read data, ready and error to the APB master. It sits between the SoC APB interconnect and all uDMA peripheral register files.

## Interface
- N_PERIPHS, 8: number of attached peripheral register files (1..16).
- TIMEOUT, 255: max cycles to wait for cfg_ready before error (1..255).
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- paddr_i  in  32  APB address; [6:2] = register address, [10:7] = peripheral index, others ignored.
- pwdata_i  in  32  APB write data.
- pwrite_i  in  1  1 = write.
- psel_i  in  1  APB select.
- penable_i  in  1  APB enable.
- prdata_o  out  32  read data, registered.
- pready_o  out  1  transfer complete, registered.
- pslverr_o  out  1  error, valid with pready_o.
- cfg_valid_o  out  N_PERIPHS  one-hot request strobe per peripheral.
- cfg_rwn_o  out  1  1 = read, 0 = write (shared).
- cfg_addr_o  out  5  register address (shared).
- cfg_data_o  out  32  write data (shared).
- cfg_data_i  in  32*N_PERIPHS  read data; peripheral k on bits [32k+31:32k].
- cfg_ready_i  in  N_PERIPHS  per-peripheral ready.

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - On psel_i & ~penable_i (setup phase), latch paddr_i[6:2], paddr_i[10:7], pwdata_i and ~pwrite_i into r_addr, r_idx, r_data and r_rwn.
  - If the index is < N_PERIPHS: set cfg_valid_o[idx], clear the timeout counter, go to REQ.
  - Otherwise: go to DONE with error=1 and prdata=0. No cfg strobe is issued.
- REQ:
  - cfg_valid_o[r_idx]=1. cfg_addr_o, cfg_data_o and cfg_rwn_o hold the latched values.
  - If cfg_ready_i[r_idx]=1: capture cfg_data_i[r_idx] into prdata (reads; writes capture 0), clear valid, go to DONE with error=0.
  - Else increment the counter. When counter == TIMEOUT-1 and ready is still low: clear valid, prdata=0, error=1, go to DONE.
- DONE:
  - pready_o=1 and pslverr_o=error for exactly one cycle, then go to IDLE.
  - prdata_o holds its value until the next capture.
- cfg_valid_o is never high for more than one cycle in which the addressed cfg_ready_i is high. Read side effects (status clear-on-read) therefore occur exactly once per APB read.
- Ready inputs of non-addressed peripherals are ignored.
- cfg_addr_o, cfg_data_o and cfg_rwn_o change only in IDLE on a setup phase.
- An APB setup phase that arrives while in REQ or DONE is not a legal APB sequence. The bridge ignores it.

## Timing
- Reset values: cfg_valid_o=0, cfg_rwn_o=1, cfg_addr_o=0, cfg_data_o=0, prdata_o=0, pready_o=0, pslverr_o=0, FSM=IDLE, counter=0.
- Setup phase in cycle T0; cfg_valid_o rises in T1.
- Peripheral ready in T1 (combinational-ready register file): pready_o=1 in T2. APB transfer is 3 cycles, 1 wait state.
- Ready asserted k cycles after T1: pready_o in T2+k.
- Timeout:
  - valid stays high for TIMEOUT cycles (T1..T_TIMEOUT).
  - pready_o=1 with pslverr_o=1 in cycle T1+TIMEOUT.
- Invalid index: pready_o=1 and pslverr_o=1 in T1, with no cfg_valid_o pulse.
- Reset asserted mid-transfer: all outputs go to their reset values immediately (asynchronous). No cfg strobe is reissued after release.
- All outputs are registered. There is no combinational path from APB or cfg inputs to any output.

## Test plan
- **Write, immediate ready.** APB write to paddr 0x0000_0094 (idx 1, reg 5), data 0x1234 -> in T1: cfg_valid_o=8'b0000_0010, cfg_addr_o=5, cfg_data_o=0x1234, cfg_rwn_o=0. In T2: pready_o=1, pslverr_o=0.
- **Read, immediate ready.** APB read of idx 0, reg 8, peripheral returns 0x3 -> prdata_o=0x3 with pready_o in T2. cfg_valid_o high for exactly 1 cycle.
- **Delayed ready.** Peripheral 2 holds ready low 4 cycles -> cfg_valid_o[2] high 5 cycles, pready_o in T6, read data equals the value sampled in the ready cycle.
- **Timeout.** TIMEOUT=4, ready never asserted -> valid high T1..T4, then pready_o=1 and pslverr_o=1 in T5, prdata_o=0.
- **Invalid index.** paddr idx 9 with N_PERIPHS=8 -> no cfg_valid_o bit set, pready_o=1 and pslverr_o=1 in T1.
- **Reset mid-transfer.** Drop rstn_i in REQ -> all outputs reach reset values in the same cycle. A following read of idx 0 completes normally in 3 cycles.
